rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (we / 3-bit Addr / data) between two requesters (req0, req1).
- Uses round-robin arbitration with optional locked bursts, bounded by MAX_BURST.
- Sits directly in front of the register file's write-enable decode stage and drives its we/Addr/data from registered outputs.
- Only one write per cycle reaches the register file, so write-port conflicts cannot occur.

Parameters:
- DATA_WIDTH, 8, width of write data.
- ADDR_WIDTH, 3, register address width (8 registers).
- MAX_BURST, 4, maximum consecutive locked transfers by one requester before the lock is forcibly broken; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 write request; addr0/data0 valid while high.
- lock0  input  1  requester 0 asks to keep ownership after this transfer.
- addr0  input  ADDR_WIDTH  requester 0 write address.
- data0  input  DATA_WIDTH  requester 0 write data.
- gnt0  output  1  combinational grant; transfer0 = req0 & gnt0 at the rising edge.
- req1, lock1, addr1, data1, gnt1: same as requester 0, for requester 1.
- rf_we  output  1  registered write enable to the register file.
- rf_addr  output  ADDR_WIDTH  registered write address.
- rf_wdata  output  DATA_WIDTH  registered write data.
- busy  output  1  high while the FSM is in LOCK0 or LOCK1.

Behaviour:
- One clock domain (clk), asynchronous active-low reset (reset_n).
- Reset values:
  - state = IDLE, rr_ptr = 0 (requester 0 favoured), burst_cnt = 0.
  - rf_we = 0, rf_addr = 0, rf_wdata = 0.
  - gnt0 = gnt1 = 0 while reset_n is low.
- Handshake:
  - Requester holds req/addr/data/lock stable until it sees gnt high at a rising edge.
  - It may then present the next write immediately (back-to-back allowed).
  - gnt never asserts without the matching req.
  - At most one gnt is high per cycle.
- Grant logic (combinational from state, rr_ptr and reqs):
  - IDLE, only reqK high: gntK = 1.
  - IDLE, both high: grant goes to the side given by rr_ptr.
  - LOCKk: only gntk may assert; the other requester is blocked.
- Latency: a transfer at edge N produces rf_we = 1 with the captured addr/data during cycle N+1. With no transfer, rf_we = 0 next cycle. rf_addr/rf_wdata hold their last value when rf_we = 0.
- FSM states: IDLE, LOCK0, LOCK1.
- On a transfer by requester k, in any state:
  - burst_cnt_next = burst_cnt + 1.
  - If lockk = 1 and burst_cnt_next < MAX_BURST: next state = LOCKk, burst_cnt = burst_cnt_next, rr_ptr unchanged.
  - Otherwise: next state = IDLE, burst_cnt = 0, rr_ptr = other requester.
- In LOCKk with reqk low: lock is abandoned. Next state = IDLE, burst_cnt = 0, rr_ptr = other requester.
- MAX_BURST = 1: lock has no effect; behaviour is pure alternation.
- lock without req is ignored.
- The lock input of the non-owning requester is ignored.
- Reset asserted mid-burst: everything clears asynchronously, rf_we drops immediately, and any in-flight write is lost.

Optional Feature:
- Macro: RF_WRITE_ARBITER_STAT_EN.
- When defined:
  - Adds outputs stat_cnt0 and stat_cnt1, each 16 bits.
  - Each counts that requester's transfers and saturates at 16'hFFFF.
  - Both clear to 0 on reset.
  - Adds output stat_brk, 1 bit, a registered pulse on every forced MAX_BURST lock break.
- When undefined: these ports and registers do not exist, and the rest of the behaviour is identical.

Decomposition:
- Shared header rf_arb_defs.vh holds:
  - FSM state encodings (IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2).
  - Requester index constants.
  - The default MAX_BURST value.
- One sub-module, rr_pick2: a combinational 2-way round-robin picker taking (req0, req1, ptr) and returning a one-hot grant. It is instantiated for the IDLE-state decision.

Test Plan:
1. Reset, then req0 = 1, addr0 = 3, data0 = 8'hA5, lock0 = 0 for one transfer:
   - gnt0 = 1 in that cycle.
   - Next cycle: rf_we = 1, rf_addr = 3, rf_wdata = A5.
   - Following cycle: rf_we = 0, rr_ptr = 1.
2. Both requesting continuously, locks low, addr0 = 1 and addr1 = 6:
   - rf_addr alternates 1, 6, 1, 6 with rf_we high every cycle.
   - The first grant goes to req0.
3. MAX_BURST = 4, req0 and lock0 held high, req1 high:
   - Exactly 4 consecutive writes from requester 0, then requester 1 is granted.
   - busy is high during the burst.
   - With the stat macro defined, stat_brk pulses once.
4. LOCK0 after 2 transfers, then req0 dropped while req1 is high:
   - FSM returns to IDLE.
   - gnt1 = 1 in that same cycle.
   - burst_cnt resets.
5. reset_n pulled low while rf_we = 1 mid-burst:
   - rf_we, rf_addr, rf_wdata and gnt clear immediately.
   - After release, req1 alone is granted first.
6. With the stat macro defined, 70000 transfers from requester 0:
   - stat_cnt0 saturates at 16'hFFFF.
   - stat_cnt1 stays 0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared FSM encodings and constants for rf_write_arbiter
package rf_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    localparam int DEFAULT_MAX_BURST = 4;

    function automatic logic other_side(input logic side);
        return ~side;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick2.sv
// rtl/rf_write_arbiter_rr_pick2.sv - combinational 2-way round-robin picker (one-hot grant)
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin write-port arbiter with bounded locked bursts
// Optional transfer statistics: define RF_WRITE_ARBITER_STAT_EN.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  lock0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt1,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy
`ifdef RF_WRITE_ARBITER_STAT_EN
    ,
    output logic [15:0]           stat_cnt0,
    output logic [15:0]           stat_cnt1,
    output logic                  stat_brk
`endif
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    arb_state_t state;
    logic       rr_ptr;
    logic [3:0] burst_cnt;
    logic [1:0] pick;
    logic [1:0] gnt;
    logic       owner_req;
    logic       arb_open;
    logic       xfer;
    logic       xfer_side;
    logic       xfer_lock;
    logic [3:0] cnt_next;
    logic       keep_lock;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .ptr  (rr_ptr),
        .gnt  (pick)
    );

    // An owner that drops its request releases the port in the same cycle,
    // so the other side can be granted without a dead cycle.
    always_comb begin
        owner_req = 1'b0;
        case (state)
            ST_LOCK0: owner_req = req0;
            ST_LOCK1: owner_req = req1;
            default:  owner_req = 1'b0;
        endcase
        arb_open = (state == ST_IDLE) || !owner_req;

        gnt = 2'b00;
        if (reset_n) begin
            if (arb_open) begin
                gnt = pick;
            end else if (state == ST_LOCK0) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end

        xfer      = |gnt;
        xfer_side = gnt[1] ? REQ_1 : REQ_0;
        xfer_lock = gnt[1] ? lock1 : lock0;
        cnt_next  = (arb_open ? 4'd0 : burst_cnt) + 4'd1;
        keep_lock = xfer_lock && (cnt_next < BURST_LIMIT);
    end

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= REQ_0;
            burst_cnt <= '0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
        end else begin
            rf_we <= xfer;
            if (xfer) begin
                rf_addr  <= gnt[1] ? addr1 : addr0;
                rf_wdata <= gnt[1] ? data1 : data0;
                if (keep_lock) begin
                    state     <= gnt[1] ? ST_LOCK1 : ST_LOCK0;
                    burst_cnt <= cnt_next;
                end else begin
                    state     <= ST_IDLE;
                    burst_cnt <= '0;
                    rr_ptr    <= other_side(xfer_side);
                end
            end else if (state != ST_IDLE) begin
                state     <= ST_IDLE;
                burst_cnt <= '0;
                rr_ptr    <= (state == ST_LOCK0) ? REQ_1 : REQ_0;
            end
        end
    end

`ifdef RF_WRITE_ARBITER_STAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
            stat_brk  <= 1'b0;
        end else begin
            if (gnt[0] && (stat_cnt0 != 16'hFFFF)) begin
                stat_cnt0 <= stat_cnt0 + 16'd1;
            end
            if (gnt[1] && (stat_cnt1 != 16'hFFFF)) begin
                stat_cnt1 <= stat_cnt1 + 16'd1;
            end
            stat_brk <= xfer && xfer_lock && !keep_lock;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter (optional RF_WRITE_ARBITER_STAT_EN)
module tb_rf_write_arbiter;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic          gnt0, gnt1, rf_we, busy;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
`ifdef RF_WRITE_ARBITER_STAT_EN
    logic [15:0]   stat_cnt0, stat_cnt1;
    logic          stat_brk;
`endif

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .lock0    (lock0),
        .addr0    (addr0),
        .data0    (data0),
        .gnt0     (gnt0),
        .req1     (req1),
        .lock1    (lock1),
        .addr1    (addr1),
        .data1    (data1),
        .gnt1     (gnt1),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .busy     (busy)
`ifdef RF_WRITE_ARBITER_STAT_EN
        ,
        .stat_cnt0(stat_cnt0),
        .stat_cnt1(stat_cnt1),
        .stat_brk (stat_brk)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          brk;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model: who owns the port, how long its locked run is, who is favoured.
    int m_owner  = -1;
    int m_run    = 0;
    int m_favour = 0;
    int m_cnt0   = 0;
    int m_cnt1   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_run    = 0;
        m_favour = 0;
        m_cnt0   = 0;
        m_cnt1   = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic r0, input logic l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         output int g);
        logic lk;
        int   n;
        wr_t  w;
        @(negedge clk);
        req0 = r0; lock0 = l0; addr0 = a0; data0 = d0;
        req1 = r1; lock1 = l1; addr1 = a1; data1 = d1;
        #1;
        g = -1;
        if (m_owner >= 0 && ((m_owner == 0) ? r0 : r1)) g = m_owner;
        else if (r0 && r1) g = m_favour;
        else if (r0) g = 0;
        else if (r1) g = 1;
        check("gnt0", gnt0, g == 0);
        check("gnt1", gnt1, g == 1);
        check("busy", busy, m_owner >= 0);
        if (g >= 0) begin
            lk     = (g == 0) ? l0 : l1;
            n      = ((m_owner == g) ? m_run : 0) + 1;
            w.addr = (g == 0) ? a0 : a1;
            w.data = (g == 0) ? d0 : d1;
            w.brk  = lk && (n >= MAXB);
            exp_q.push_back(w);
            if (lk && n < MAXB) begin
                m_owner = g;
                m_run   = n;
            end else begin
                m_owner  = -1;
                m_run    = 0;
                m_favour = 1 - g;
            end
            if (g == 0 && m_cnt0 < 65535) m_cnt0++;
            if (g == 1 && m_cnt1 < 65535) m_cnt1++;
        end else if (m_owner >= 0) begin
            m_favour = 1 - m_owner;
            m_owner  = -1;
            m_run    = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_busy", busy, 0);
`ifdef RF_WRITE_ARBITER_STAT_EN
        check("rst_stat_cnt0", stat_cnt0, 0);
        check("rst_stat_cnt1", stat_cnt1, 0);
`endif
        reset_n = 1'b1;
    endtask

    // Monitor: every registered write must match the oldest expected transfer.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            check("rf_we", rf_we, exp_q.size() != 0);
            if (rf_we && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rf_addr", rf_addr, e.addr);
                check("rf_wdata", rf_wdata, e.data);
`ifdef RF_WRITE_ARBITER_STAT_EN
                check("stat_brk", stat_brk, e.brk);
            end else begin
                check("stat_brk_idle", stat_brk, 0);
`endif
            end
        end
    end

    initial begin
        int            g;
        int            run;
        logic          pend[2];
        logic          plock[2];
        logic [AW-1:0] pa[2];
        logic [DW-1:0] pd[2];

        do_reset();

        // Single unlocked transfer from requester 0
        drive(1, 0, 3'd3, 8'hA5, 0, 0, 0, 0, g);
        check("t1_gnt0", gnt0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, g);
        check("t1_rf_we", rf_we, 1);
        check("t1_rf_addr", rf_addr, 3);
        check("t1_rf_wdata", rf_wdata, 8'hA5);
        drive(0, 0, 0, 0, 0, 0, 0, 0, g);
        check("t1_rf_we_off", rf_we, 0);
        drive(1, 0, 3'd2, 8'h11, 1, 0, 3'd4, 8'h22, g);
        check("t1_ptr_gnt1", gnt1, 1);

        // Continuous alternation
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 3'd1, DW'(8'h40 + i), 1, 0, 3'd6, DW'(8'h80 + i), g);
            if (i == 0) check("t2_first_gnt0", gnt0, 1);
        end

        // Locked burst bounded by MAXB
        run = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 3'd5, DW'(i), 1, 0, 3'd7, 8'hEE, g);
            if (gnt1) break;
            if (gnt0) run++;
        end
        check("t3_burst_len", run, MAXB);

        // Lock abandoned after two transfers
        drive(1, 1, 3'd0, 8'h01, 0, 0, 0, 0, g);
        drive(1, 1, 3'd0, 8'h02, 0, 0, 0, 0, g);
        drive(0, 1, 3'd0, 8'h03, 1, 0, 3'd2, 8'h5A, g);
        check("t4_gnt1", gnt1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, g);
        check("t4_busy_off", busy, 0);

        // Asynchronous reset mid-burst
        drive(1, 1, 3'd4, 8'hC3, 0, 0, 0, 0, g);
        drive(1, 1, 3'd4, 8'hC4, 0, 0, 0, 0, g);
        @(posedge clk);
        #3;
        check("t5_rf_we_pre", rf_we, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rf_we", rf_we, 0);
        check("t5_rf_addr", rf_addr, 0);
        check("t5_rf_wdata", rf_wdata, 0);
        check("t5_gnt0", gnt0, 0);
        model_reset();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("t5_gnt0_in_rst", gnt0, 0);
        check("t5_gnt1_in_rst", gnt1, 0);
        req0 = 1'b0; req1 = 1'b0;
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 3'd5, 8'h3C, g);
        check("t5_gnt1_first", gnt1, 1);

        // Randomised traffic: requesters hold until granted
        pend[0] = 1'b0; pend[1] = 1'b0;
        plock[0] = 1'b0; plock[1] = 1'b0;
        pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 99) < 70) begin
                    pend[k]  = 1'b1;
                    pa[k]    = AW'($urandom);
                    pd[k]    = DW'($urandom);
                    plock[k] = ($urandom_range(0, 99) < 60);
                end
            end
            drive(pend[0], pend[0] ? plock[0] : 1'($urandom), pend[0] ? pa[0] : AW'($urandom), pd[0],
                  pend[1], pend[1] ? plock[1] : 1'($urandom), pend[1] ? pa[1] : AW'($urandom), pd[1], g);
            if (g >= 0) pend[g] = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, g);
        drive(0, 0, 0, 0, 0, 0, 0, 0, g);
`ifdef RF_WRITE_ARBITER_STAT_EN
        check("rand_stat_cnt0", stat_cnt0, m_cnt0);
        check("rand_stat_cnt1", stat_cnt1, m_cnt1);

        do_reset();
        for (int c = 0; c < 70000; c++) begin
            drive(1, 0, AW'(c), DW'(c), 0, 0, 0, 0, g);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, g);
        check("t6_stat_cnt0", stat_cnt0, 16'hFFFF);
        check("t6_stat_cnt1", stat_cnt1, 0);
        check("t6_model_cnt0", stat_cnt0, m_cnt0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, g);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
